// File: rtl/outport_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : outport_ctrl_pkg
// Purpose  : Shared constants for the wormhole-router output-port controller.
//            Holds the port count, flit width, flit-type codes and small
//            helpers that decode the type field of a flit.
// Revision : 1.0  initial release
// ============================================================================
package outport_ctrl_pkg;

    // Highest port index; port vectors are [c_PORT:0].
    localparam int c_PORT = 4;

    // Flit width; the two MSBs carry the flit type.
    localparam int c_FW = 34;

    // Flit type codes (bits [FW-1:FW-2]).
    localparam logic [1:0] c_FT_BODY = 2'b00;
    localparam logic [1:0] c_FT_HEAD = 2'b01;
    localparam logic [1:0] c_FT_TAIL = 2'b10;
    localparam logic [1:0] c_FT_HT   = 2'b11;

    // A flit opens a packet when it is a head or a single-flit head+tail.
    function automatic logic ft_is_head(input logic [1:0] ft);
        return (ft == c_FT_HEAD) || (ft == c_FT_HT);
    endfunction

    // A flit closes a packet when it is a tail or a single-flit head+tail.
    function automatic logic ft_is_tail(input logic [1:0] ft);
        return (ft == c_FT_TAIL) || (ft == c_FT_HT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/outport_ctrl_credit_cnt.sv
`default_nettype none
// ============================================================================
// Module   : outport_ctrl_credit_cnt
// Purpose  : Downstream credit counter. Resets to CREDIT, decrements on a
//            forwarded flit, increments on a returned credit, saturates at
//            CREDIT and raises a sticky overflow flag when a credit is
//            returned to a full counter.
// Ports    : clk      - clock
//            rst_     - asynchronous active-low reset
//            i_inc    - one credit returned by downstream
//            i_dec    - one flit forwarded (only asserted when count != 0)
//            o_count  - current credit count
//            o_ovf    - sticky overflow error
// Revision : 1.0  initial release
// ============================================================================
module outport_ctrl_credit_cnt #(
    parameter int CREDIT = 4,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_ovf
);

    localparam logic [CW-1:0] c_FULL = CW'(CREDIT);
    localparam logic [CW-1:0] c_STEP = CW'(1);

    logic [CW-1:0] r_count;
    logic          r_ovf;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_count <= c_FULL;
            r_ovf   <= 1'b0;
        end else begin
            case ({i_inc, i_dec})
                2'b01: r_count <= r_count - c_STEP;
                2'b10: begin
                    // A return to a full counter means downstream and this
                    // block disagree on buffer depth: hold and flag it.
                    if (r_count == c_FULL) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_count <= r_count + c_STEP;
                    end
                end
                default: ; // idle, or a return cancelling a forward
            endcase
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/outport_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : outport_ctrl
// Purpose  : Per-output-port controller of the 5-port wormhole router.
//            Requests the arbiter on behalf of inputs holding head flits,
//            locks the granted input until its tail flit passes, drives the
//            crossbar select, registers the outgoing flit and tracks
//            downstream credits.
// Ports    : clk        - clock
//            rst_       - asynchronous active-low reset
//            in_vld     - input-buffer head valid, one bit per input
//            in_flit    - packed head flits, port i at [i*FW +: FW]
//            in_ack     - one-hot pop to the owning input (combinational)
//            arb_req    - request vector to the arbiter (combinational)
//            arb_grt    - grant from the arbiter
//            sel        - crossbar select, equals the owner register
//            out_vld    - registered flit valid toward downstream
//            out_flit   - registered flit
//            credit_in  - one credit returned by downstream
//            cr_ovf     - sticky credit-overflow error
// Revision : 1.0  initial release
// ============================================================================
module outport_ctrl
    import outport_ctrl_pkg::*;
#(
    parameter int PORT   = c_PORT,
    parameter int FW     = c_FW,
    parameter int CREDIT = 4,
    parameter int CW     = 3
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [PORT:0]          in_vld,
    input  logic [(PORT+1)*FW-1:0] in_flit,
    output logic [PORT:0]          in_ack,
    output logic [PORT:0]          arb_req,
    input  logic [PORT:0]          arb_grt,
    output logic [PORT:0]          sel,
    output logic                   out_vld,
    output logic [FW-1:0]          out_flit,
    input  logic                   credit_in,
    output logic                   cr_ovf
);

    localparam logic [0:0]    c_IDLE   = 1'b0;
    localparam logic [0:0]    c_ACTIVE = 1'b1;
    localparam logic [PORT:0] c_ONE    = (PORT+1)'(1);

    logic [0:0]    r_state;
    logic [PORT:0] r_owner;
    logic          r_out_vld;
    logic [FW-1:0] r_out_flit;

    logic [PORT:0] w_is_head;
    logic [PORT:0] w_grant_low;
    logic [FW-1:0] w_flit;
    logic [CW-1:0] w_credits;
    logic          w_has_credit;
    logic          w_xfer;
    logic          w_tail;

    // Decode which input buffers present a packet-opening flit.
    generate
        for (genvar gi = 0; gi <= PORT; gi++) begin : g_port
            assign w_is_head[gi] = ft_is_head(in_flit[gi*FW + FW-2 +: 2]);
        end
    endgenerate

    // Owner flit mux; owner is one-hot or zero, so OR-reduction suffices.
    always_comb begin
        w_flit = '0;
        for (int i = 0; i <= PORT; i++) begin
            if (r_owner[i]) begin
                w_flit = w_flit | in_flit[i*FW +: FW];
            end
        end
    end

    // Keep only the lowest set grant bit so the owner stays one-hot.
    assign w_grant_low  = arb_grt & (~arb_grt + c_ONE);

    assign w_has_credit = (w_credits != '0);
    assign w_xfer       = (r_state == c_ACTIVE) && (|(r_owner & in_vld)) && w_has_credit;
    assign w_tail       = ft_is_tail(w_flit[FW-1:FW-2]);

    // Body/tail flits at an idle input are never requested; they wait
    // for their own head to win this port first.
    assign arb_req  = (r_state == c_IDLE) ? (in_vld & w_is_head) : '0;
    assign in_ack   = w_xfer ? r_owner : '0;
    assign sel      = r_owner;
    assign out_vld  = r_out_vld;
    assign out_flit = r_out_flit;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= c_IDLE;
            r_owner <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // A grant without credit is dropped; the arbiter is
                    // asked again next cycle.
                    if ((|arb_grt) && w_has_credit) begin
                        r_state <= c_ACTIVE;
                        r_owner <= w_grant_low;
                    end
                end
                c_ACTIVE: begin
                    if (w_xfer && w_tail) begin
                        r_state <= c_IDLE;
                        r_owner <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_owner <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_out_vld  <= 1'b0;
            r_out_flit <= '0;
        end else begin
            r_out_vld <= w_xfer;
            if (w_xfer) begin
                r_out_flit <= w_flit;
            end
        end
    end

    outport_ctrl_credit_cnt #(
        .CREDIT (CREDIT),
        .CW     (CW)
    ) u_credit (
        .clk     (clk),
        .rst_    (rst_),
        .i_inc   (credit_in),
        .i_dec   (w_xfer),
        .o_count (w_credits),
        .o_ovf   (cr_ovf)
    );

endmodule
`default_nettype wire

// File: tb/tb_outport_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_outport_ctrl
// Purpose  : Directed self-checking bench for outport_ctrl. Models the input
//            buffers as per-port queues popped by in_ack and a lowest-index
//            fixed-priority arbiter (with a grant override).
// Revision : 1.0  initial release
// ============================================================================
module tb_outport_ctrl;
    import outport_ctrl_pkg::*;

    localparam int P = 4;
    localparam int W = 34;

    logic               clk = 1'b0;
    logic               rst_;
    logic [P:0]         in_vld;
    logic [(P+1)*W-1:0] in_flit;
    logic [P:0]         in_ack;
    logic [P:0]         arb_req;
    logic [P:0]         arb_grt;
    logic [P:0]         sel;
    logic               out_vld;
    logic [W-1:0]       out_flit;
    logic               credit_in;
    logic               cr_ovf;
    logic               force_en;
    logic [P:0]         force_grt;

    logic [W-1:0] q [0:P][$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign arb_grt = force_en ? force_grt : (arb_req & (~arb_req + 5'd1));

    outport_ctrl #(.PORT(P), .FW(W), .CREDIT(4), .CW(3)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .in_vld    (in_vld),
        .in_flit   (in_flit),
        .in_ack    (in_ack),
        .arb_req   (arb_req),
        .arb_grt   (arb_grt),
        .sel       (sel),
        .out_vld   (out_vld),
        .out_flit  (out_flit),
        .credit_in (credit_in),
        .cr_ovf    (cr_ovf)
    );

    function automatic logic [W-1:0] mk(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i <= P; i++) begin
            in_vld[i] = (q[i].size() != 0);
            in_flit[i*W +: W] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    // Middle of the current cycle: all checks happen here.
    task automatic mid();
        @(negedge clk);
    endtask

    // Close the cycle: capture pops, cross the edge, apply them.
    task automatic adv();
        logic [P:0] a;
        #1;
        a = in_ack;
        @(posedge clk);
        #1;
        for (int i = 0; i <= P; i++) begin
            if (a[i] && q[i].size() != 0) void'(q[i].pop_front());
        end
        refresh();
    endtask

    task automatic give_credits(input int n);
        credit_in = 1'b1;
        repeat (n) begin
            mid();
            adv();
        end
        credit_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_      = 1'b0;
        in_vld    = '0;
        in_flit   = '0;
        credit_in = 1'b0;
        force_en  = 1'b0;
        force_grt = '0;

        // ---------------- reset then idle ----------------
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        mid();
        chk("rst_sel",     64'(sel),           64'h0);
        chk("rst_out_vld", 64'(out_vld),       64'h0);
        chk("rst_flit",    64'(out_flit),      64'h0);
        chk("rst_credits", 64'(dut.w_credits), 64'h4);
        chk("rst_ovf",     64'(cr_ovf),        64'h0);
        chk("rst_req",     64'(arb_req),       64'h0);
        chk("rst_ack",     64'(in_ack),        64'h0);
        adv();

        // ---------------- priority and lock ----------------
        q[1].push_back(mk(c_FT_HEAD, 32'h101));
        q[1].push_back(mk(c_FT_BODY, 32'h102));
        q[1].push_back(mk(c_FT_TAIL, 32'h103));
        q[3].push_back(mk(c_FT_HT,   32'h301));
        refresh();
        mid();
        chk("a0_req", 64'(arb_req), 64'h0a);
        chk("a0_grt", 64'(arb_grt), 64'h02);
        chk("a0_sel", 64'(sel),     64'h0);
        chk("a0_ack", 64'(in_ack),  64'h0);
        adv();
        mid();
        chk("a1_sel", 64'(sel),     64'h02);
        chk("a1_req", 64'(arb_req), 64'h0);
        chk("a1_ack", 64'(in_ack),  64'h02);
        chk("a1_vld", 64'(out_vld), 64'h0);
        adv();
        mid();
        chk("a2_vld",  64'(out_vld),  64'h1);
        chk("a2_flit", 64'(out_flit), 64'(mk(c_FT_HEAD, 32'h101)));
        chk("a2_req",  64'(arb_req),  64'h0);
        adv();
        mid();
        chk("a3_vld",  64'(out_vld),  64'h1);
        chk("a3_flit", 64'(out_flit), 64'(mk(c_FT_BODY, 32'h102)));
        adv();
        mid();
        chk("a4_flit", 64'(out_flit), 64'(mk(c_FT_TAIL, 32'h103)));
        chk("a4_sel",  64'(sel),      64'h0);
        chk("a4_grt",  64'(arb_grt),  64'h08);
        adv();
        mid();
        chk("a5_sel",  64'(sel),      64'h08);
        chk("a5_vld",  64'(out_vld),  64'h0);
        chk("a5_hold", 64'(out_flit), 64'(mk(c_FT_TAIL, 32'h103)));
        adv();
        mid();
        chk("a6_vld",     64'(out_vld),       64'h1);
        chk("a6_flit",    64'(out_flit),      64'(mk(c_FT_HT, 32'h301)));
        chk("a6_credits", 64'(dut.w_credits), 64'h0);
        adv();

        // ---------------- credit exhaustion ----------------
        give_credits(4);
        q[2].push_back(mk(c_FT_HEAD, 32'h200));
        for (int k = 1; k <= 4; k++) q[2].push_back(mk(c_FT_BODY, 32'h200 + 32'(k)));
        q[2].push_back(mk(c_FT_TAIL, 32'h205));
        refresh();
        mid();
        chk("b0_credits", 64'(dut.w_credits), 64'h4);
        chk("b0_grt",     64'(arb_grt),       64'h04);
        adv();
        for (int k = 1; k <= 4; k++) begin
            mid();
            chk("b_ack", 64'(in_ack), 64'h04);
            adv();
        end
        mid();
        chk("b5_ack",     64'(in_ack),        64'h0);
        chk("b5_vld",     64'(out_vld),       64'h1);
        chk("b5_flit",    64'(out_flit),      64'(mk(c_FT_BODY, 32'h203)));
        chk("b5_credits", 64'(dut.w_credits), 64'h0);
        adv();
        credit_in = 1'b1;
        mid();
        chk("b6_vld", 64'(out_vld), 64'h0);
        chk("b6_ack", 64'(in_ack),  64'h0);
        chk("b6_sel", 64'(sel),     64'h04);
        adv();
        credit_in = 1'b0;
        mid();
        chk("b7_credits", 64'(dut.w_credits), 64'h1);
        chk("b7_ack",     64'(in_ack),        64'h04);
        adv();
        credit_in = 1'b1;
        mid();
        chk("b8_vld",  64'(out_vld),  64'h1);
        chk("b8_flit", 64'(out_flit), 64'(mk(c_FT_BODY, 32'h204)));
        chk("b8_ack",  64'(in_ack),   64'h0);
        adv();
        credit_in = 1'b0;
        mid();
        chk("b9_ack", 64'(in_ack), 64'h04);
        adv();

        // ---------------- grant ignored without credit ----------------
        q[0].push_back(mk(c_FT_HT, 32'h0a0));
        refresh();
        mid();
        chk("b10_flit", 64'(out_flit), 64'(mk(c_FT_TAIL, 32'h205)));
        chk("b10_sel",  64'(sel),      64'h0);
        chk("b10_req",  64'(arb_req),  64'h01);
        adv();
        credit_in = 1'b1;
        mid();
        chk("z11_sel", 64'(sel), 64'h0);
        adv();
        credit_in = 1'b0;
        mid();
        chk("z12_sel",     64'(sel),           64'h0);
        chk("z12_credits", 64'(dut.w_credits), 64'h1);
        adv();
        mid();
        chk("z13_sel", 64'(sel),    64'h01);
        chk("z13_ack", 64'(in_ack), 64'h01);
        adv();
        mid();
        chk("z14_vld",  64'(out_vld),  64'h1);
        chk("z14_flit", 64'(out_flit), 64'(mk(c_FT_HT, 32'h0a0)));
        adv();

        // ---------------- simultaneous credit and transfer ----------------
        give_credits(2);
        q[4].push_back(mk(c_FT_HEAD, 32'h400));
        q[4].push_back(mk(c_FT_BODY, 32'h401));
        q[4].push_back(mk(c_FT_TAIL, 32'h402));
        refresh();
        mid();
        adv();
        credit_in = 1'b1;
        mid();
        chk("s1_credits", 64'(dut.w_credits), 64'h2);
        chk("s1_ack",     64'(in_ack),        64'h10);
        adv();
        credit_in = 1'b0;
        mid();
        chk("s2_credits", 64'(dut.w_credits), 64'h2);
        adv();
        mid();
        chk("s3_credits", 64'(dut.w_credits), 64'h1);
        adv();
        mid();
        chk("s4_flit",    64'(out_flit),      64'(mk(c_FT_TAIL, 32'h402)));
        chk("s4_credits", 64'(dut.w_credits), 64'h0);
        chk("s4_sel",     64'(sel),           64'h0);
        adv();
        give_credits(4);

        // ---------------- head+tail back-to-back ----------------
        q[0].push_back(mk(c_FT_HT, 32'h0b0));
        q[2].push_back(mk(c_FT_HT, 32'h2b0));
        refresh();
        mid();
        chk("h0_grt", 64'(arb_grt), 64'h01);
        adv();
        mid();
        chk("h1_ack", 64'(in_ack), 64'h01);
        adv();
        mid();
        chk("h2_vld",  64'(out_vld),  64'h1);
        chk("h2_flit", 64'(out_flit), 64'(mk(c_FT_HT, 32'h0b0)));
        chk("h2_sel",  64'(sel),      64'h0);
        chk("h2_grt",  64'(arb_grt),  64'h04);
        adv();
        mid();
        chk("h3_ack", 64'(in_ack), 64'h04);
        adv();
        mid();
        chk("h4_vld",     64'(out_vld),       64'h1);
        chk("h4_flit",    64'(out_flit),      64'(mk(c_FT_HT, 32'h2b0)));
        chk("h4_credits", 64'(dut.w_credits), 64'h2);
        adv();

        // ---------------- multi-bit grant keeps lowest ----------------
        q[2].push_back(mk(c_FT_HT, 32'h2c0));
        q[4].push_back(mk(c_FT_HT, 32'h4c0));
        force_en  = 1'b1;
        force_grt = 5'b10100;
        refresh();
        mid();
        adv();
        force_en = 1'b0;
        mid();
        chk("m1_sel", 64'(sel),    64'h04);
        chk("m1_ack", 64'(in_ack), 64'h04);
        adv();
        mid();
        chk("m2_flit", 64'(out_flit), 64'(mk(c_FT_HT, 32'h2c0)));
        chk("m2_grt",  64'(arb_grt),  64'h10);
        adv();
        mid();
        adv();
        mid();
        chk("m4_flit",    64'(out_flit),      64'(mk(c_FT_HT, 32'h4c0)));
        chk("m4_credits", 64'(dut.w_credits), 64'h0);
        adv();

        // ---------------- overflow ----------------
        give_credits(4);
        mid();
        chk("o_credits_full", 64'(dut.w_credits), 64'h4);
        chk("o_ovf_clear",    64'(cr_ovf),        64'h0);
        adv();
        give_credits(1);
        mid();
        chk("o_ovf_set", 64'(cr_ovf),        64'h1);
        chk("o_credits", 64'(dut.w_credits), 64'h4);
        adv();
        mid();
        chk("o_ovf_sticky", 64'(cr_ovf), 64'h1);
        adv();

        // ---------------- reset mid-packet ----------------
        q[1].push_back(mk(c_FT_HEAD, 32'h1d0));
        q[1].push_back(mk(c_FT_BODY, 32'h1d1));
        q[1].push_back(mk(c_FT_BODY, 32'h1d2));
        q[1].push_back(mk(c_FT_TAIL, 32'h1d3));
        refresh();
        mid();
        adv();
        mid();
        adv();
        mid();
        chk("r2_vld", 64'(out_vld), 64'h1);
        chk("r2_sel", 64'(sel),     64'h02);
        rst_ = 1'b0;
        adv();
        mid();
        chk("r_sel",     64'(sel),           64'h0);
        chk("r_vld",     64'(out_vld),       64'h0);
        chk("r_flit",    64'(out_flit),      64'h0);
        chk("r_credits", 64'(dut.w_credits), 64'h4);
        chk("r_ovf",     64'(cr_ovf),        64'h0);
        chk("r_ack",     64'(in_ack),        64'h0);
        adv();
        rst_ = 1'b1;
        mid();
        chk("r_body_noreq", 64'(arb_req), 64'h0);
        chk("r_sel_after",  64'(sel),     64'h0);
        adv();
        for (int i = 0; i <= P; i++) q[i].delete();
        refresh();
        mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/outport_ctrl.md
Name: outport_ctrl

Overview:
- Per-output-port controller of the 5-port wormhole router; one instance per output direction.
- Sits directly downstream of the fixed-priority arbiter. Presents head-flit requests to the arbiter and consumes its grant.
- Locks the winning input to this output until that input's tail flit passes, and drives the crossbar select.
- Registers the outgoing flit and tracks downstream buffer credits.

Parameters:
- PORT, `PORT from defines.h (4): highest port index; port vectors are [PORT:0].
- FW, 34: flit width; bits [FW-1:FW-2] are the flit type: 00 body, 01 head, 10 tail, 11 head+tail.
- CREDIT, 4: downstream input-buffer depth; reset value of the credit counter.
- CW, 3: credit counter width; must hold CREDIT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_  in  1  asynchronous active-low reset.
- in_vld  in  PORT+1  input-buffer head valid, one bit per input port.
- in_flit  in  (PORT+1)*FW  head flits of the input buffers, packed; port i occupies [i*FW +: FW].
- in_ack  out  PORT+1  one-hot pop to the owning input buffer; combinational.
- arb_req  out  PORT+1  request vector to the arbiter; combinational.
- arb_grt  in  PORT+1  grant from the arbiter; combinational from arb_req.
- sel  out  PORT+1  crossbar select, one-hot; equals the owner register.
- out_vld  out  1  registered flit valid toward the downstream router.
- out_flit  out  FW  registered flit.
- credit_in  in  1  one credit returned by downstream; one per cycle maximum.
- cr_ovf  out  1  sticky error: credit returned while the counter is full.

Behaviour:
- Reset (asynchronous, rst_ low) drives:
  - state = IDLE, owner = 0, sel = 0
  - credits = CREDIT
  - out_vld = 0, out_flit = 0, cr_ovf = 0
  - in_ack = 0 combinationally while in reset.
- Reset asserted mid-packet abandons the lock immediately; no partial flit is emitted.
- Two states, IDLE and ACTIVE.
- IDLE:
  - arb_req[i] = in_vld[i] & (type of flit i is head or head+tail).
  - A body or tail flit at the head of an idle input is not requested; it waits.
- IDLE -> ACTIVE:
  - Taken when arb_grt != 0 and credits != 0; owner is loaded with arb_grt.
  - If arb_grt has several bits set, only the lowest set bit is kept.
  - No flit transfers in the grant cycle.
- Grant received while credits == 0 is ignored; the block stays IDLE and re-arbitrates next cycle.
- ACTIVE:
  - arb_req = 0.
  - Transfer condition: xfer = |(owner & in_vld) & (credits != 0).
  - On xfer: in_ack = owner; next cycle out_vld = 1 and out_flit = the owner's flit.
  - Otherwise in_ack = 0 and next cycle out_vld = 0; out_flit holds its value.
- ACTIVE -> IDLE: when the flit transferred this cycle has type tail or head+tail; owner is cleared on the same edge.
- Latency:
  - Grant in cycle N: in_ack in cycle N+1, out_vld in cycle N+2.
  - A single-flit (head+tail) packet returns to IDLE at N+2, so the next grant can occur at N+2.
- Credit counter update:
  - xfer and no credit_in: decrement.
  - credit_in and no xfer: increment.
  - Both together: unchanged.
  - Counter never underflows, because xfer requires credits != 0.
  - credit_in while credits == CREDIT and no xfer: counter stays at CREDIT and cr_ovf is set (sticky until reset).
- Stall: owner in_vld low, or credits == 0, keeps the lock held indefinitely; no timeout.
- sel is valid whenever state is ACTIVE and is 0 in IDLE.

Decomposition:
- Shared package / defines.h:
  - `PORT
  - flit type codes: FT_BODY 2'b00, FT_HEAD 2'b01, FT_TAIL 2'b10, FT_HT 2'b11
  - FW
- The arbiter is instantiated outside this block; the arb_req/arb_grt pair connects to it.
- Natural sub-module: credit_cnt (up/down counter with saturation and overflow flag), instantiated once.
- Flit mux and FSM stay inline.

Test Plan:
- Reset then idle: rst_ low for 2 cycles, release -> sel=0, out_vld=0, credits=4, arb_req=0 with in_vld=0.
- Priority and lock:
  - Stimulus: head flits on ports 1 and 3 at cycle 0; port 1 sends 3 flits (head, body, tail).
  - Arbiter grants 5'b00010 -> sel=5'b00010 from cycle 1.
  - out_vld high on cycles 2-4 with port 1 flits in order; arb_req=0 during the lock.
  - Port 3 granted at cycle 4; its flit is on out_vld at cycle 6.
- Credit exhaustion:
  - Stimulus: CREDIT=4, credit_in=0, 6-flit packet.
  - Exactly 4 flits forwarded, then in_ack=0 and the lock is held.
  - One credit_in pulse -> the 5th flit is forwarded one cycle later.
- Simultaneous credit and transfer: credits=2, xfer and credit_in in the same cycle -> credits remain 2.
- Head+tail back-to-back:
  - Stimulus: ports 0 and 2 each hold one HT flit.
  - Port 0 is forwarded at cycle 2, IDLE at cycle 2, port 2 granted at cycle 2, port 2 flit out at cycle 4.
- Overflow and mid-packet reset:
  - credit_in at credits=4 -> cr_ovf=1 and stays high.
  - rst_ low during an ACTIVE packet -> next sampled sel=0, out_vld=0, credits=4, cr_ovf=0.
